// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: measures VGA line/frame timing and an active-pixel
// checksum, publishes the results at every VS start and tracks whether
// consecutive frames are identical.
module vga_frame_monitor #(
   parameter int   CNT_W  = 12,
   parameter logic HS_POL = 1'b0,
   parameter logic VS_POL = 1'b0
) (
   input  logic             clk_clk,
   input  logic             reset_reset,
   input  logic             vga_HS,
   input  logic             vga_VS,
   input  logic             vga_BLANK,
   input  logic [7:0]       vga_R,
   input  logic [7:0]       vga_G,
   input  logic [7:0]       vga_B,
   input  logic             clear_err,
   output logic [CNT_W-1:0] h_total,
   output logic [CNT_W-1:0] h_active,
   output logic [CNT_W-1:0] v_total,
   output logic [CNT_W-1:0] v_active,
   output logic [31:0]      frame_csum,
   output logic             frame_done,
   output logic             locked,
   output logic             err_mismatch,
   output logic             err_overflow
);
   localparam logic [CNT_W-1:0] CMAX = '1;
   localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {SEARCH, MEASURE, TRACK} state_t;
   state_t state;

   logic             hs_r, vs_r, hs_q, vs_q, blank_r;
   logic [23:0]      rgb_r;
   logic [CNT_W-1:0] hcnt, acnt, line_len, ha_cand, lcnt, alcnt;
   logic [31:0]      csum;
   logic             hs_start, vs_start, ovf, match;
   logic [CNT_W-1:0] len_nx, ha_nx, lcnt_nx, alcnt_nx;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CMAX) ? v : v + ONE;
   endfunction

   // Register every video input once; hs_q/vs_q hold the previous copy for edge detection.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         hs_r    <= ~HS_POL;
         vs_r    <= ~VS_POL;
         hs_q    <= ~HS_POL;
         vs_q    <= ~VS_POL;
         blank_r <= 1'b0;
         rgb_r   <= '0;
      end else begin
         hs_r    <= vga_HS;
         vs_r    <= vga_VS;
         hs_q    <= hs_r;
         vs_q    <= vs_r;
         blank_r <= vga_BLANK;
         rgb_r   <= {vga_R, vga_G, vga_B};
      end
   end

   assign hs_start = (hs_r == HS_POL) && (hs_q != HS_POL);
   assign vs_start = (vs_r == VS_POL) && (vs_q != VS_POL);

   // Frame values including the line closed this cycle, so a coincident HS start lands in the published frame.
   always_comb begin
      len_nx   = line_len;
      ha_nx    = ha_cand;
      lcnt_nx  = lcnt;
      alcnt_nx = alcnt;
      if (hs_start) begin
         len_nx  = hcnt;
         lcnt_nx = sat_inc(lcnt);
         if (acnt != '0) begin
            alcnt_nx = sat_inc(alcnt);
            ha_nx    = acnt;
         end
      end
   end

   assign ovf   = (hcnt == CMAX) || (acnt == CMAX) || (lcnt == CMAX) || (alcnt == CMAX);
   assign match = (len_nx == h_total) && (ha_nx == h_active) && (lcnt_nx == v_total) &&
                  (alcnt_nx == v_active) && (csum == frame_csum);

   // Line counters run freely; frame accumulators restart at every VS start.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         hcnt     <= '0;
         acnt     <= '0;
         line_len <= '0;
         ha_cand  <= '0;
         lcnt     <= '0;
         alcnt    <= '0;
         csum     <= '0;
      end else begin
         if (hs_start) begin
            hcnt <= ONE;
            acnt <= {{(CNT_W-1){1'b0}}, blank_r};
         end else begin
            hcnt <= sat_inc(hcnt);
            if (blank_r) acnt <= sat_inc(acnt);
         end
         line_len <= len_nx;
         if (vs_start) begin
            ha_cand <= '0;
            lcnt    <= '0;
            alcnt   <= '0;
            csum    <= '0;
         end else begin
            ha_cand <= ha_nx;
            lcnt    <= lcnt_nx;
            alcnt   <= alcnt_nx;
            if (blank_r) csum <= {csum[30:0], csum[31]} ^ {8'h00, rgb_r};
         end
      end
   end

   // Lock FSM: publishes results, compares against the previous frame, keeps sticky errors.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state        <= SEARCH;
         h_total      <= '0;
         h_active     <= '0;
         v_total      <= '0;
         v_active     <= '0;
         frame_csum   <= '0;
         frame_done   <= 1'b0;
         locked       <= 1'b0;
         err_mismatch <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (clear_err) begin
            err_mismatch <= 1'b0;
            err_overflow <= 1'b0;
         end
         if (ovf) begin
            state        <= SEARCH;
            locked       <= 1'b0;
            err_overflow <= 1'b1;
         end else if (vs_start) begin
            case (state)
               SEARCH: state <= MEASURE;
               MEASURE, TRACK: begin
                  h_total    <= len_nx;
                  h_active   <= ha_nx;
                  v_total    <= lcnt_nx;
                  v_active   <= alcnt_nx;
                  frame_csum <= csum;
                  frame_done <= 1'b1;
                  if (state == TRACK) begin
                     locked <= match;
                     if (!match) err_mismatch <= 1'b1;
                  end
                  state <= TRACK;
               end
               default: state <= SEARCH;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb_vga_frame_monitor: drives synthetic VGA frames and checks published
// results against a frame-level model (publish at VS reports the previous frame).
module tb_vga_frame_monitor;
   localparam int CNT_W = 12;

   logic             clk = 1'b0;
   logic             reset_reset, vga_HS, vga_VS, vga_BLANK, clear_err;
   logic [7:0]       vga_R, vga_G, vga_B;
   logic [CNT_W-1:0] h_total, h_active, v_total, v_active;
   logic [31:0]      frame_csum;
   logic             frame_done, locked, err_mismatch, err_overflow;

   vga_frame_monitor #(.CNT_W(CNT_W), .HS_POL(1'b0), .VS_POL(1'b0)) dut (
      .clk_clk(clk), .reset_reset(reset_reset), .vga_HS(vga_HS), .vga_VS(vga_VS),
      .vga_BLANK(vga_BLANK), .vga_R(vga_R), .vga_G(vga_G), .vga_B(vga_B),
      .clear_err(clear_err), .h_total(h_total), .h_active(h_active), .v_total(v_total),
      .v_active(v_active), .frame_csum(frame_csum), .frame_done(frame_done),
      .locked(locked), .err_mismatch(err_mismatch), .err_overflow(err_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          ht;
      int          ha;
      int          nl;
      int          na;
      logic [31:0] cs;
   } frm_t;

   int   total = 0, bad = 0;
   int   cyc = 0, done_cnt = 0, done_cyc = -1, vs_cyc = 0, pulses = 0;
   int   vs_seen = 0;
   frm_t prv, lastpub, exp_f;
   bit   m_locked = 0, m_mis = 0, m_ovf = 0, exp_pub = 0;
   logic [4*CNT_W+35:0] snap;

   function automatic bit frm_eq(input frm_t a, input frm_t b);
      return a.ht == b.ht && a.ha == b.ha && a.nl == b.nl && a.na == b.na && a.cs == b.cs;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (frame_done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
   endtask

   task automatic put(input logic hs, input logic vs, input logic bl, input logic [23:0] px);
      vga_HS    = hs;
      vga_VS    = vs;
      vga_BLANK = bl;
      {vga_R, vga_G, vga_B} = px;
      tick();
   endtask

   // Frame-level model of a VS start: the window just closed is the previous frame.
   task automatic model_vs();
      exp_pub = (vs_seen > 0);
      if (exp_pub) begin
         exp_f = prv;
         if (vs_seen > 1) begin
            m_locked = frm_eq(prv, lastpub);
            if (!m_locked) m_mis = 1;
         end
         lastpub = prv;
      end
      vs_seen++;
   endtask

   // One frame: HS at pos 0..1, active pos 2..ha+1 on lines 1..na, VS at line0 pos3 (pos0 if co).
   // ev_kind 1 = clear_err pulse, 2 = reset pulse, at (ev_l, ev_p).
   task automatic run_frame(input int ht, input int ha, input int nl, input int na,
                            input int pm, input bit co, input int ev_kind, input int ev_l, input int ev_p);
      int          d0;
      logic [31:0] cs;
      logic [23:0] px;
      bit          hs_a, vs_a, bl, ev;
      d0 = done_cnt;
      cs = 32'h0;
      for (int l = 0; l < nl; l++) begin
         for (int p = 0; p < ht; p++) begin
            hs_a = (p < 2);
            vs_a = co ? (l == 0) : ((l == 0 && p >= 3) || (l == 1 && p < 3));
            bl   = (l >= 1 && l <= na && p >= 2 && p < 2 + ha);
            px   = 24'h0;
            if (bl) begin
               if (pm == 2) px = 24'($urandom_range(0, 24'hFFFFFF));
               else if (pm == 1 && l == na && p == 1 + ha) px = 24'h000001;
               cs = {cs[30:0], cs[31]} ^ {8'h00, px};
            end
            ev          = (l == ev_l && p == ev_p);
            clear_err   = (ev_kind == 1) && ev;
            reset_reset = (ev_kind == 2) && ev;
            put(~hs_a, ~vs_a, bl, px);
            if (l == 0 && p == (co ? 0 : 3)) begin
               vs_cyc = cyc;
               model_vs();
            end
            if (ev_kind == 1 && ev) begin
               m_mis = 0;
               m_ovf = 0;
            end
            if (ev_kind == 2 && ev) begin
               snap = {h_total, h_active, v_total, v_active, frame_csum,
                       frame_done, locked, err_mismatch, err_overflow};
               vs_seen  = 0;
               m_locked = 0;
               m_mis    = 0;
               m_ovf    = 0;
            end
         end
      end
      clear_err   = 1'b0;
      reset_reset = 1'b0;
      pulses = done_cnt - d0;
      prv.ht = ht;
      prv.ha = ha;
      prv.nl = nl;
      prv.na = na;
      prv.cs = cs;
   endtask

   task automatic test_reset();
      reset_reset = 1'b1;
      clear_err   = 1'b0;
      put(1'b1, 1'b1, 1'b0, 24'h0);
      put(1'b1, 1'b1, 1'b0, 24'h0);
      reset_reset = 1'b0;
      put(1'b1, 1'b1, 1'b0, 24'h0);
      total++;
      if ({h_total, h_active, v_total, v_active} !== '0) begin
         bad++;
         $display("FAIL reset_results got %h want 0", {h_total, h_active, v_total, v_active});
      end
      total++;
      if (frame_csum !== 32'h0) begin
         bad++;
         $display("FAIL reset_csum got %h want 0", frame_csum);
      end
      total++;
      if ({frame_done, locked, err_mismatch, err_overflow} !== 4'b0) begin
         bad++;
         $display("FAIL reset_flags got %b want 0000", {frame_done, locked, err_mismatch, err_overflow});
      end
   endtask

   task automatic test_identical();
      int p = 0;
      for (int k = 0; k < 3; k++) begin
         run_frame(10, 6, 5, 3, 0, 1'b0, 0, -1, -1);
         p += pulses;
      end
      total++;
      if (p != 2) begin
         bad++;
         $display("FAIL ident_pulses got %0d want 2", p);
      end
      total++;
      if (done_cyc != vs_cyc + 1) begin
         bad++;
         $display("FAIL ident_done_latency got %0d want %0d", done_cyc - vs_cyc, 1);
      end
      total++;
      if ({h_total, h_active, v_total, v_active} !== {12'd10, 12'd6, 12'd5, 12'd3}) begin
         bad++;
         $display("FAIL ident_results got %0d/%0d/%0d/%0d want 10/6/5/3", h_total, h_active, v_total, v_active);
      end
      total++;
      if (frame_csum !== 32'h0) begin
         bad++;
         $display("FAIL ident_csum got %h want 00000000", frame_csum);
      end
      total++;
      if (locked !== m_locked || locked !== 1'b1) begin
         bad++;
         $display("FAIL ident_locked got %b want %b", locked, m_locked);
      end
   endtask

   task automatic test_mismatch();
      run_frame(11, 6, 5, 3, 0, 1'b0, 0, -1, -1);
      run_frame(10, 6, 5, 3, 0, 1'b0, 0, -1, -1);
      total++;
      if (h_total !== CNT_W'(exp_f.ht)) begin
         bad++;
         $display("FAIL mis_htotal got %0d want %0d", h_total, exp_f.ht);
      end
      total++;
      if ({locked, err_mismatch} !== {m_locked, m_mis} || err_mismatch !== 1'b1) begin
         bad++;
         $display("FAIL mis_flags got %b%b want %b%b", locked, err_mismatch, m_locked, m_mis);
      end
      run_frame(10, 6, 5, 3, 0, 1'b0, 1, 2, 0);
      total++;
      if (err_mismatch !== m_mis || err_mismatch !== 1'b0) begin
         bad++;
         $display("FAIL mis_clear got %b want %b", err_mismatch, m_mis);
      end
   endtask

   task automatic test_csum_pixel();
      run_frame(10, 6, 5, 3, 1, 1'b0, 0, -1, -1);
      run_frame(10, 6, 5, 3, 0, 1'b0, 0, -1, -1);
      total++;
      if (frame_csum !== exp_f.cs || frame_csum !== 32'h00000001) begin
         bad++;
         $display("FAIL csum_pixel got %h want %h", frame_csum, exp_f.cs);
      end
   endtask

   task automatic test_overflow();
      run_frame(10, 6, 5, 3, 0, 1'b0, 0, -1, -1);
      run_frame(10, 6, 5, 3, 0, 1'b0, 0, -1, -1);
      total++;
      if (locked !== m_locked || locked !== 1'b1) begin
         bad++;
         $display("FAIL ovf_prelock got %b want %b", locked, m_locked);
      end
      for (int i = 0; i < 4096; i++) put(1'b0, 1'b1, 1'b0, 24'h0);
      for (int i = 0; i < 5; i++) put(1'b1, 1'b1, 1'b0, 24'h0);
      vs_seen  = 0;
      m_locked = 0;
      m_ovf    = 1;
      total++;
      if ({err_overflow, locked} !== {m_ovf, m_locked}) begin
         bad++;
         $display("FAIL ovf_flags got %b%b want %b%b", err_overflow, locked, m_ovf, m_locked);
      end
      run_frame(10, 6, 5, 3, 0, 1'b0, 0, -1, -1);
      total++;
      if (pulses != 0) begin
         bad++;
         $display("FAIL ovf_first_vs got %0d pulses want 0", pulses);
      end
      run_frame(10, 6, 5, 3, 0, 1'b0, 0, -1, -1);
      total++;
      if (pulses != 1 || v_total !== CNT_W'(exp_f.nl)) begin
         bad++;
         $display("FAIL ovf_second_vs got %0d pulses v_total %0d want 1 and %0d", pulses, v_total, exp_f.nl);
      end
   endtask

   task automatic test_coincident();
      for (int k = 0; k < 2; k++) begin
         run_frame(10, 6, 5, 3, 0, 1'b1, 0, -1, -1);
         total++;
         if (pulses != 1 || v_total !== CNT_W'(exp_f.nl) || v_total !== 12'd5) begin
            bad++;
            $display("FAIL coinc_vtotal got %0d (pulses %0d) want %0d", v_total, pulses, exp_f.nl);
         end
      end
   endtask

   task automatic test_reset_midframe();
      run_frame(10, 6, 5, 3, 0, 1'b0, 2, 2, 4);
      total++;
      if (snap !== '0) begin
         bad++;
         $display("FAIL midrst_outputs got %h want 0", snap);
      end
      run_frame(10, 6, 5, 3, 0, 1'b0, 0, -1, -1);
      total++;
      if (pulses != 0) begin
         bad++;
         $display("FAIL midrst_next_vs got %0d pulses want 0", pulses);
      end
      run_frame(10, 6, 5, 3, 0, 1'b0, 0, -1, -1);
      total++;
      if (pulses != 1) begin
         bad++;
         $display("FAIL midrst_resume got %0d pulses want 1", pulses);
      end
   endtask

   task automatic test_random();
      int ht = 10, ha = 6, nl = 5, na = 3, pm;
      bit co;
      for (int k = 0; k < 10; k++) begin
         if ($urandom_range(0, 1) == 1) begin
            ht = int'($urandom_range(12, 40));
            ha = int'($urandom_range(1, ht - 4));
            nl = int'($urandom_range(4, 9));
            na = int'($urandom_range(1, nl - 1));
         end
         pm = ($urandom_range(0, 1) == 1) ? 2 : 0;
         co = 1'($urandom_range(0, 1));
         run_frame(ht, ha, nl, na, pm, co, 0, -1, -1);
         total++;
         if (pulses != (exp_pub ? 1 : 0)) begin
            bad++;
            $display("FAIL rnd_pulses frame %0d got %0d want %0d", k, pulses, exp_pub);
         end
         if (exp_pub) begin
            total++;
            if (h_total !== CNT_W'(exp_f.ht) || h_active !== CNT_W'(exp_f.ha) ||
                v_total !== CNT_W'(exp_f.nl) || v_active !== CNT_W'(exp_f.na)) begin
               bad++;
               $display("FAIL rnd_timing frame %0d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", k,
                        h_total, h_active, v_total, v_active, exp_f.ht, exp_f.ha, exp_f.nl, exp_f.na);
            end
            total++;
            if (frame_csum !== exp_f.cs) begin
               bad++;
               $display("FAIL rnd_csum frame %0d got %h want %h", k, frame_csum, exp_f.cs);
            end
            total++;
            if (done_cyc != vs_cyc + 1) begin
               bad++;
               $display("FAIL rnd_latency frame %0d got %0d want 1", k, done_cyc - vs_cyc);
            end
         end
         total++;
         if ({locked, err_mismatch, err_overflow} !== {m_locked, m_mis, m_ovf}) begin
            bad++;
            $display("FAIL rnd_flags frame %0d got %b%b%b want %b%b%b", k,
                     locked, err_mismatch, err_overflow, m_locked, m_mis, m_ovf);
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      vga_HS = 1'b1;
      vga_VS = 1'b1;
      vga_BLANK = 1'b0;
      {vga_R, vga_G, vga_B} = 24'h0;
      reset_reset = 1'b1;
      clear_err = 1'b0;
      test_reset();
      test_identical();
      test_mismatch();
      test_csum_pixel();
      test_overflow();
      test_coincident();
      test_reset_midframe();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
